// File: rtl/load_store_unit.sv
// Data-memory initiator for RISC-V byte/half/word loads and stores.
// Sub-word stores are done as read-modify-write on a word-addressed memory.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    // state   | meaning
    // ST_IDLE | ready for a request
    // ST_RD   | memory word read, captured into rdbuf
    // ST_WR   | memory word written (full word or merged lane)
    // ST_RESP | one-cycle response pulse
    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} state_t;

    state_t      state, state_nxt;
    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] rdbuf;
    logic [31:0] lat_idx;
    logic        req_err;
    logic        accept;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept  = (state == ST_IDLE) && req_valid;
    assign lat_idx = {2'b00, lat_addr[31:2]};

    assign req_err = (req_funct3 == 3'b011)
                  || (req_funct3[2:1] == 2'b11)
                  || (req_we && req_funct3[2])
                  || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                  || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00))
                  || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    assign rd_byte = mem_RD[{lat_addr[1:0], 3'b000} +: 8];
    assign rd_half = mem_RD[{lat_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (lat_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = mem_RD;
        endcase
    end

    // Sub-word stores splice the new lane into the word captured during ST_RD.
    always_comb begin
        merge_data = rdbuf;
        case (lat_funct3[1:0])
            2'b00:   merge_data[{lat_addr[1:0], 3'b000} +: 8]  = lat_wdata[7:0];
            2'b01:   merge_data[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: merge_data = lat_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            rdbuf      <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_we     <= req_we;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                if (req_err) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b1;
                end
            end
            if (state == ST_RD) begin
                rdbuf <= mem_RD;
                if (!lat_we) begin
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
            end
            if (state == ST_WR) begin
                resp_rdata <= 32'h0;
                resp_err   <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_A     = 32'h0;
        mem_WE    = 1'b0;
        mem_WD    = 32'h0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = ST_RESP;
                    else if (req_we && (req_funct3 == 3'b010))
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                mem_A     = lat_idx;
                state_nxt = lat_we ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                mem_A     = lat_idx;
                mem_WE    = 1'b1;
                mem_WD    = merge_data;
                state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached memory, request-level reference model,
// per-cycle output compare and directed vectors with literal expectations.
module tb_load_store_unit;
    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    assign mem_RD = (mem_A < 32'(MW)) ? mem[mem_A[5:0]] : 32'h0;
    always @(posedge clk) if (mem_WE) mem[mem_A[5:0]] <= mem_WD;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one outstanding request, expressed as cycle numbers
    // relative to the acceptance edge.
    int          busy_until  = -10;
    int          exp_resp_cyc = -1;
    int          exp_rd_cyc  = -1;
    int          exp_we_cyc  = -1;
    int          acc_cyc     = -1;
    int          acc_count   = 0;
    logic [31:0] exp_rdata   = 32'h0;
    logic        exp_err     = 1'b0;
    logic [31:0] exp_idx     = 32'h0;
    logic [31:0] exp_wd      = 32'h0;

    task automatic model_accept();
        logic [31:0] a, word, v, r, mask;
        logic [2:0]  f3;
        int sz, sh, lat;
        logic bad;
        a  = req_addr;
        f3 = req_funct3;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (req_we && f3 >= 3'd4)
           || (a % sz != 0) || ((a >> 2) >= MW);
        acc_cyc = cyc;
        acc_count++;
        exp_idx = a >> 2;
        exp_rd_cyc = -1;
        exp_we_cyc = -1;
        if (bad) begin
            lat = 1;
            exp_rdata = 32'h0;
            exp_err = 1'b1;
        end else begin
            word = ref_mem[exp_idx[5:0]];
            sh = 8 * int'(a % 4);
            exp_err = 1'b0;
            if (!req_we) begin
                lat = 2;
                exp_rd_cyc = cyc;
                v = word >> sh;
                if (sz == 1) begin
                    r = v & 32'hFF;
                    if (!f3[2] && r >= 32'h80) r = r | 32'hFFFFFF00;
                end else if (sz == 2) begin
                    r = v & 32'hFFFF;
                    if (!f3[2] && r >= 32'h8000) r = r | 32'hFFFF0000;
                end else begin
                    r = word;
                end
                exp_rdata = r;
            end else begin
                lat = (sz == 4) ? 2 : 3;
                if (sz != 4) exp_rd_cyc = cyc;
                exp_we_cyc = cyc + lat - 2;
                mask = (sz == 4) ? 32'hFFFFFFFF : (((32'h1 << (8 * sz)) - 1) << sh);
                exp_wd = (word & ~mask) | ((req_wdata << sh) & mask);
                exp_rdata = 32'h0;
            end
        end
        exp_resp_cyc = cyc + lat - 1;
        busy_until = exp_resp_cyc;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (cyc == exp_we_cyc + 1) ref_mem[exp_idx[5:0]] = exp_wd;
            if (req_valid && cyc >= busy_until + 2) model_accept();
        end
    end

    always @(posedge rst) begin
        busy_until   = -10;
        exp_resp_cyc = -1;
        exp_rd_cyc   = -1;
        exp_we_cyc   = -1;
        exp_rdata    = 32'h0;
        exp_err      = 1'b0;
    end

    logic [31:0] cap_rdata = 32'h0;
    logic        cap_err = 1'b0;
    int          cap_cyc = -1;
    int          resp_cnt = 0;
    int          we_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_mem_WE", mem_WE, 0);
            chk("rst_mem_A", mem_A, 0);
            chk("rst_mem_WD", mem_WD, 0);
        end else begin
            chk("resp_valid", resp_valid, cyc == exp_resp_cyc);
            chk("req_ready", req_ready, cyc > busy_until);
            chk("mem_WE", mem_WE, cyc == exp_we_cyc);
            if (cyc == exp_resp_cyc || cyc > busy_until) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", resp_err, exp_err);
            end
            if (cyc == exp_rd_cyc || cyc == exp_we_cyc) chk("mem_A", mem_A, exp_idx);
            else chk("mem_A_idle", mem_A, 0);
            if (cyc == exp_we_cyc) chk("mem_WD", mem_WD, exp_wd);
            else if (cyc != exp_rd_cyc) chk("mem_WD_idle", mem_WD, 0);
            if (resp_valid) begin
                cap_rdata = resp_rdata;
                cap_err   = resp_err;
                cap_cyc   = cyc;
                resp_cnt++;
            end
            if (mem_WE) we_cnt++;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        n = acc_count;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && acc_count == n; i++) begin
            @(posedge clk);
            #2;
        end
        chk("accepted", 32'(acc_count - n), 1);
    endtask

    task automatic wait_idle();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && cyc <= busy_until; i++) begin
            @(posedge clk);
            #2;
        end
        chk("idle_reached", cyc > busy_until, 1);
    endtask

    task automatic run(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_rdata, input int e_lat, input int e_wr);
        int r0, w0;
        r0 = resp_cnt;
        w0 = we_cnt;
        issue(we, f3, addr, wd);
        wait_idle();
        chk({name, "_resp_cnt"}, 32'(resp_cnt - r0), 1);
        chk({name, "_latency"}, 32'(cap_cyc - acc_cyc), 32'(e_lat));
        chk({name, "_err"}, cap_err, e_err);
        chk({name, "_rdata"}, cap_rdata, e_rdata);
        chk({name, "_writes"}, 32'(we_cnt - w0), 32'(e_wr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        for (int i = 0; i < MW; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        run("sw_init", 1, 3'b010, 32'h14, 32'h11223344, 0, 32'h0, 1, 1);
        run("lw_init", 0, 3'b010, 32'h14, 32'h0, 0, 32'h11223344, 1, 0);
        run("sw_pat", 1, 3'b010, 32'h14, 32'h80FF7F01, 0, 32'h0, 1, 1);
        run("lb", 0, 3'b000, 32'h17, 32'h0, 0, 32'hFFFFFF80, 1, 0);
        run("lbu", 0, 3'b100, 32'h17, 32'h0, 0, 32'h00000080, 1, 0);
        run("lb_pos", 0, 3'b000, 32'h15, 32'h0, 0, 32'h0000007F, 1, 0);
        run("lh", 0, 3'b001, 32'h16, 32'h0, 0, 32'hFFFF80FF, 1, 0);
        run("lhu", 0, 3'b101, 32'h16, 32'h0, 0, 32'h000080FF, 1, 0);
        run("lw", 0, 3'b010, 32'h14, 32'h0, 0, 32'h80FF7F01, 1, 0);

        run("sw_rst1", 1, 3'b010, 32'h14, 32'h11223344, 0, 32'h0, 1, 1);
        run("sb", 1, 3'b000, 32'h15, 32'hFFFFFFAB, 0, 32'h0, 2, 1);
        run("lw_sb", 0, 3'b010, 32'h14, 32'h0, 0, 32'h1122AB44, 1, 0);
        run("sw_rst2", 1, 3'b010, 32'h14, 32'h11223344, 0, 32'h0, 1, 1);
        run("sh", 1, 3'b001, 32'h16, 32'h1234BEEF, 0, 32'h0, 2, 1);
        run("lw_sh", 0, 3'b010, 32'h14, 32'h0, 0, 32'hBEEF3344, 1, 0);
        run("sw_rst3", 1, 3'b010, 32'h14, 32'h11223344, 0, 32'h0, 1, 1);

        run("err_lw_mis", 0, 3'b010, 32'h16, 32'h0, 1, 32'h0, 0, 0);
        run("err_sh_mis", 1, 3'b001, 32'h13, 32'hBEEF, 1, 32'h0, 0, 0);
        run("err_st_bu", 1, 3'b100, 32'h14, 32'h55, 1, 32'h0, 0, 0);
        run("err_f3_111", 0, 3'b111, 32'h14, 32'h0, 1, 32'h0, 0, 0);
        run("err_range", 0, 3'b010, 32'(4 * MW), 32'h0, 1, 32'h0, 0, 0);
        run("lw_last", 0, 3'b010, 32'(4 * MW - 4), 32'h0, 0, 32'h0, 1, 0);

        r0 = resp_cnt;
        w0 = we_cnt;
        issue(1, 3'b000, 32'h14, 32'hCD);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_mem_WE_async", mem_WE, 0);
        chk("abort_req_ready", req_ready, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("abort_no_write", 32'(we_cnt - w0), 0);
        chk("abort_no_resp", 32'(resp_cnt - r0), 0);
        run("lw_after_abort", 0, 3'b010, 32'h14, 32'h0, 0, 32'h11223344, 1, 0);

        r0 = resp_cnt;
        issue(0, 3'b010, 32'h14, 32'h0);
        issue(1, 3'b000, 32'h14, 32'h5A);
        issue(0, 3'b100, 32'h14, 32'h0);
        issue(0, 3'b111, 32'h14, 32'h0);
        wait_idle();
        chk("b2b_resp_cnt", 32'(resp_cnt - r0), 4);
        chk("b2b_last_err", cap_err, 1);
        run("lw_b2b", 0, 3'b010, 32'h14, 32'h0, 0, 32'h1122335A, 1, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
